// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the register file writeback arbiter
package regfile_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int DEF_DATA_WIDTH = 32;

  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_LSU = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_fwd_unit.sv
// rtl/wb_fwd_unit.sv - compares one read address against the registered writeback for forwarding
module wb_fwd_unit
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] rw_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [REG_ADDR_W-1:0] chk_addr,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data
);

  // x0 is hardwired to zero, so it can never be a forwarding source
  assign fwd_hit  = wr_en && (rw_addr == chk_addr) && (chk_addr != '0);
  assign fwd_data = fwd_hit ? wr_data : '0;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/LSU writeback arbiter with LSU starvation guard
// Optional forwarding ports and compare logic under REGFILE_WB_FWD_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef REGFILE_WB_FWD_EN
  input  logic [REG_ADDR_W-1:0] chk_addr1,
  input  logic [REG_ADDR_W-1:0] chk_addr2,
  output logic                  fwd_hit1,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data2,
`endif
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] rw_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  wb_state_t             state, state_next;
  logic [3:0]            cnt, cnt_next;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  do_write;

  always_comb begin
    alu_ready  = 1'b0;
    lsu_ready  = 1'b0;
    state_next = state;
    cnt_next   = cnt;

    if (!rst) begin
      if (alu_valid && (!lsu_valid || state == PRI_ALU))
        alu_ready = 1'b1;
      else if (lsu_valid)
        lsu_ready = 1'b1;
    end

    if (!lsu_valid || lsu_ready)
      cnt_next = '0;
    else if (state == PRI_ALU && alu_ready)
      cnt_next = cnt + 4'd1;

    case (state)
      PRI_ALU: if (lsu_valid && alu_ready && (cnt + 4'd1) == WAIT_LIM) state_next = PRI_LSU;
      PRI_LSU: if (lsu_ready) state_next = PRI_ALU;
      default: state_next = PRI_ALU;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PRI_ALU;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign sel_rd   = alu_ready ? alu_rd   : lsu_rd;
  assign sel_data = alu_ready ? alu_data : lsu_data;
  // x0 writes are accepted but squashed; address/data keep the last real write
  assign do_write = (alu_ready || lsu_ready) && (sel_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      rw_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        rw_addr <= sel_rd;
        wr_data <= sel_data;
      end
    end
  end

`ifdef REGFILE_WB_FWD_EN
  wb_fwd_unit #(.DATA_WIDTH(DATA_WIDTH)) u_fwd1 (
    .wr_en    (wr_en),
    .rw_addr  (rw_addr),
    .wr_data  (wr_data),
    .chk_addr (chk_addr1),
    .fwd_hit  (fwd_hit1),
    .fwd_data (fwd_data1)
  );

  wb_fwd_unit #(.DATA_WIDTH(DATA_WIDTH)) u_fwd2 (
    .wr_en    (wr_en),
    .rw_addr  (rw_addr),
    .wr_data  (wr_data),
    .chk_addr (chk_addr2),
    .fwd_hit  (fwd_hit2),
    .fwd_data (fwd_data2)
  );
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the write data width.
REQ-002 The block SHALL have parameter MAX_WAIT, default 3, giving the LSU starvation limit in cycles (range 1..15).
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-004 Port list, one per line:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  5  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  load writeback request.
- lsu_rd  in  5  load destination register.
- lsu_data  in  DATA_WIDTH  load data.
- lsu_ready  out  1  LSU request accepted this cycle.
- wr_en  out  1  register file write enable.
- rw_addr  out  5  register file write address.
- wr_data  out  DATA_WIDTH  register file write data.

Function
REQ-005 Handshake SHALL be valid/ready; a transfer occurs on a rising edge with valid && ready; a requester holds valid, rd and data stable until its transfer.
REQ-006 Ready SHALL be combinational from valids and FSM state; at most one ready is high per cycle; ready SHALL be low when the matching valid is low.
REQ-007 FSM states SHALL be PRI_ALU and PRI_LSU. In PRI_ALU the ALU wins when both are valid; in PRI_LSU the LSU wins.
REQ-008 A 4-bit starvation counter SHALL increment each cycle in PRI_ALU when lsu_valid && alu transfer. It SHALL clear when lsu_valid is low or on an LSU transfer.
REQ-009 PRI_ALU -> PRI_LSU SHALL occur on the edge where the counter would reach MAX_WAIT; PRI_LSU -> PRI_ALU SHALL occur on the LSU transfer edge, and the counter clears at that edge.
REQ-010 A single valid requester SHALL be granted in the same cycle regardless of state.
REQ-011 The output stage SHALL be registered with latency 1: on the edge after a transfer, wr_en = 1 and rw_addr/wr_data hold the transferred rd/data for exactly one cycle.
REQ-012 A transfer with rd == 0 SHALL be accepted (ready high) but SHALL produce wr_en = 0 for that cycle.
REQ-013 Back-to-back transfers SHALL be sustained at one write per cycle with no bubble.
REQ-014 With no transfer, wr_en SHALL be 0; rw_addr/wr_data SHALL hold their last values.

Reset
REQ-015 While rst is high, wr_en SHALL be 0, rw_addr SHALL be 0, wr_data SHALL be 0, the state SHALL be PRI_ALU and the counter SHALL be 0; alu_ready/lsu_ready SHALL be 0.
REQ-016 A reset asserted mid-operation SHALL drop any accepted-but-unwritten transfer; no write SHALL be issued for it after reset.

Configuration
REQ-017 Macro REGFILE_WB_FWD_EN, when defined, SHALL add these ports:
- chk_addr1 in 5
- chk_addr2 in 5
- fwd_hit1 out 1
- fwd_data1 out DATA_WIDTH
- fwd_hit2 out 1
- fwd_data2 out DATA_WIDTH
REQ-018 With REGFILE_WB_FWD_EN defined, fwd_hitN SHALL be the combinational result of wr_en && rw_addr == chk_addrN && chk_addrN != 0; fwd_dataN = wr_data when hit, else 0.
REQ-019 Without REGFILE_WB_FWD_EN, those ports and logic SHALL be absent and all other behaviour unchanged.

Structure
REQ-020 Shared package regfile_pkg SHALL hold REG_ADDR_W = 5, DEF_DATA_WIDTH = 32 and the FSM state type {PRI_ALU, PRI_LSU}.
REQ-021 The forwarding compare SHALL be a sub-module wb_fwd_unit, instantiated twice only under REGFILE_WB_FWD_EN.

Verification
REQ-022 ALU only: alu_valid=1, rd=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle wr_en=1, rw_addr=5, wr_data=0xDEADBEEF.
REQ-023 Contention: both valid continuously, MAX_WAIT=3 -> ALU granted cycles 0-2, LSU granted cycle 3, ALU cycle 4.
REQ-024 x0 discard: lsu_valid=1, rd=0, data=0x1234 -> lsu_ready=1; next cycle wr_en=0.
REQ-025 Reset mid-op: ALU transfer at edge N, rst high before edge N+1 -> wr_en=0, rw_addr=0, state PRI_ALU, no write after release.
REQ-026 Forwarding (macro on): transfer rd=7, data=0xA5A5A5A5, chk_addr1=7, chk_addr2=0 -> next cycle fwd_hit1=1, fwd_data1=0xA5A5A5A5, fwd_hit2=0.
REQ-027 Back-to-back: 4 consecutive ALU transfers rd=1..4 -> wr_en high 4 consecutive cycles, rw_addr 1,2,3,4.
